// File: rtl/vram_sched_pkg.sv
// Shared sizes and FSM encoding for the vram line scheduler.
// A frame is NUM_LINES lines of LINE_BYTES bytes each, fetched one line at a time.
package vram_sched_pkg;

  localparam int VRAM_DEPTH = 57600;
  localparam int LINE_BYTES = 1440;
  localparam int NUM_LINES  = VRAM_DEPTH / LINE_BYTES;
  localparam int VRAM_AW    = 24;
  localparam int LB_AW      = 13;
  localparam int LINE_W     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

endpackage

// File: rtl/vram_line_scheduler_if.sv
// Bus bundle between the line scheduler and its neighbours.
// The neighbours are the host writer, vram port A, the line buffer write port and the TX packetiser.
interface vram_line_scheduler_if;
  import vram_sched_pkg::*;

  logic               start;
  logic               host_req;
  logic [VRAM_AW-1:0] host_addr;
  logic [7:0]         host_din;
  logic               host_gnt;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_din;
  logic               vram_we;
  logic [7:0]         vram_dout;
  logic [LB_AW-1:0]   lb_addr;
  logic [7:0]         lb_din;
  logic               lb_we;
  logic               line_ready;
  logic [LINE_W-1:0]  line_num;
  logic               line_done;
  logic               busy;
  logic               frame_done;

  modport master (
    input  start, host_req, host_addr, host_din, vram_dout, line_done,
    output host_gnt, vram_addr, vram_din, vram_we,
           lb_addr, lb_din, lb_we, line_ready, line_num, busy, frame_done
  );

  modport slave (
    output start, host_req, host_addr, host_din, vram_dout, line_done,
    input  host_gnt, vram_addr, vram_din, vram_we,
           lb_addr, lb_din, lb_we, line_ready, line_num, busy, frame_done
  );

endinterface

// File: rtl/vram_port_arb.sv
// Two-requester arbiter for vram port A: host writer versus line fetch reads.
// The host wins outright outside FETCH; inside FETCH it yields every other cycle.
module vram_port_arb
  import vram_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_active,
  input  logic               host_req,
  input  logic [VRAM_AW-1:0] host_addr,
  input  logic [VRAM_AW-1:0] fetch_addr,
  output logic               host_gnt,
  output logic               fetch_gnt,
  output logic [VRAM_AW-1:0] vram_addr
);

  logic host_won;

  always_ff @(posedge clk) begin
    if (rst) begin
      host_won <= 1'b0;
    end else begin
      host_won <= host_gnt;
    end
  end

  // A host grant in the previous cycle hands the next fetch cycle to the line fetch.
  always_comb begin
    host_gnt  = host_req && !(fetch_active && host_won);
    fetch_gnt = fetch_active && !host_gnt;
    vram_addr = host_gnt ? host_addr : fetch_addr;
  end

endmodule

// File: rtl/vram_line_scheduler.sv
// Frame sequencer: copies vram one line at a time into the line buffer and hands each
// filled buffer to the TX packetiser, sharing vram port A with the host writer.
module vram_line_scheduler
  import vram_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vram_line_scheduler_if.master bus
);

  state_t             state, state_nxt;
  logic [LINE_W-1:0]  line, line_nxt;
  logic [VRAM_AW-1:0] base, base_nxt;
  logic [LB_AW-1:0]   rd_cnt, rd_cnt_nxt;
  logic [LB_AW-1:0]   wr_cnt, wr_cnt_nxt;
  logic               rd_vld;
  logic               line_ready, line_ready_nxt;
  logic               frame_done, frame_done_nxt;

  logic               fetch_active;
  logic               fetch_gnt;
  logic               host_gnt;
  logic [VRAM_AW-1:0] fetch_addr;
  logic [VRAM_AW-1:0] vram_addr;

  assign fetch_active = (state == FETCH);
  assign fetch_addr   = base + VRAM_AW'(rd_cnt);

  vram_port_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .fetch_active (fetch_active),
    .host_req     (bus.host_req),
    .host_addr    (bus.host_addr),
    .fetch_addr   (fetch_addr),
    .host_gnt     (host_gnt),
    .fetch_gnt    (fetch_gnt),
    .vram_addr    (vram_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line       <= '0;
      base       <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      rd_vld     <= 1'b0;
      line_ready <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      line       <= line_nxt;
      base       <= base_nxt;
      rd_cnt     <= rd_cnt_nxt;
      wr_cnt     <= wr_cnt_nxt;
      rd_vld     <= fetch_gnt;
      line_ready <= line_ready_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Reads only advance rd_cnt when granted, so a host-stolen cycle just repeats the address.
  always_comb begin
    state_nxt      = state;
    line_nxt       = line;
    base_nxt       = base;
    rd_cnt_nxt     = rd_cnt;
    wr_cnt_nxt     = rd_vld ? wr_cnt + 1'b1 : wr_cnt;
    line_ready_nxt = line_ready;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt  = FETCH;
          line_nxt   = '0;
          base_nxt   = '0;
          rd_cnt_nxt = '0;
          wr_cnt_nxt = '0;
        end
      end
      FETCH: begin
        if (fetch_gnt) begin
          rd_cnt_nxt = rd_cnt + 1'b1;
          if (rd_cnt == LB_AW'(LINE_BYTES - 1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_nxt      = WAIT_TX;
        line_ready_nxt = 1'b1;
      end
      WAIT_TX: begin
        if (bus.line_done) begin
          line_ready_nxt = 1'b0;
          if (line == LINE_W'(NUM_LINES - 1)) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b1;
          end else begin
            state_nxt  = FETCH;
            line_nxt   = line + 1'b1;
            base_nxt   = base + VRAM_AW'(LINE_BYTES);
            rd_cnt_nxt = '0;
            wr_cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // lb_din comes straight off the vram's registered read port, aligned with rd_vld.
  assign bus.host_gnt   = host_gnt;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_din   = bus.host_din;
  assign bus.vram_we    = host_gnt;
  assign bus.lb_addr    = wr_cnt;
  assign bus.lb_din     = bus.vram_dout;
  assign bus.lb_we      = rd_vld;
  assign bus.line_ready = line_ready;
  assign bus.line_num   = line;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_vram_line_scheduler.sv
// Randomized scoreboard bench for vram_line_scheduler with behavioural vram and line buffer.
// Expected line-buffer writes are queued when a line fetch is requested and popped by a monitor.
module tb_vram_line_scheduler;
  import vram_sched_pkg::*;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  vram_line_scheduler_if bus();

  vram_line_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] vram_mem [VRAM_DEPTH];
  logic [7:0] ref_mem  [VRAM_DEPTH];
  logic [7:0] lb_mem   [LINE_BYTES];
  logic [7:0] vram_dout_r;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_we = 0;
  int   first_we = -1;
  int   last_we = -1;
  int   frame_pulses = 0;
  int   base_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // vram port A: synchronous write, 1-cycle registered read
  always @(posedge clk) begin
    if (bus.vram_we && int'(bus.vram_addr) < VRAM_DEPTH)
      vram_mem[int'(bus.vram_addr)] <= bus.vram_din;
    if (int'(bus.vram_addr) < VRAM_DEPTH)
      vram_dout_r <= vram_mem[int'(bus.vram_addr)];
  end
  assign bus.vram_dout = vram_dout_r;

  always @(posedge clk) begin
    if (bus.lb_we && int'(bus.lb_addr) < LINE_BYTES)
      lb_mem[int'(bus.lb_addr)] <= bus.lb_din;
  end

  function automatic logic [7:0] pattern(input int i);
    return 8'((1 + 11 * i) % 255);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_line(input int ln);
    for (int k = 0; k < LINE_BYTES; k++) begin
      exp_t e;
      e.addr = k;
      e.data = int'(ref_mem[ln * LINE_BYTES + k]);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every line buffer write must match the next queued expectation
  always @(negedge clk) begin
    #1;
    if (bus.lb_we === 1'b1) begin
      n_we++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL lb_unexpected: write addr %0d data %0d, expected no write", bus.lb_addr, bus.lb_din);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("lb_addr", 32'(bus.lb_addr), 32'(e.addr));
        check_output("lb_din", 32'(bus.lb_din), 32'(e.data));
      end
    end
    if (bus.frame_done === 1'b1) frame_pulses++;
  end

  // Called on a negedge: issues start for cycle 0 and returns on the negedge of cycle 1
  task automatic begin_frame();
    bus.start = 1'b1;
    push_line(0);
    n_we = 0;
    first_we = -1;
    last_we = -1;
    @(negedge clk);
    bus.start = 1'b0;
    base_cyc = cyc - 1;
  endtask

  // Runs cycles k=1.. of a line fetch until line_ready (or stop_k), optionally flooding host writes
  task automatic fetch_line(input int start_k, input int done_k, input int stop_k, input bit flood,
                            output int rk, output int gerr, output int aerr);
    int k;
    int a;
    k = 1;
    rk = -1;
    gerr = 0;
    aerr = 0;
    while (k <= 4000) begin
      if (bus.line_ready === 1'b1) begin
        rk = k;
        break;
      end
      if (k == stop_k) begin
        rk = k;
        break;
      end
      bus.start = (k == start_k);
      bus.line_done = (k == done_k);
      if (flood) begin
        a = $urandom_range(50000, VRAM_DEPTH - 1);
        bus.host_req = 1'b1;
        bus.host_addr = VRAM_AW'(a);
        bus.host_din = pattern(a);
      end
      #1;
      if (flood) begin
        if (k <= 2 * LINE_BYTES && bus.host_gnt !== (k % 2 == 1)) gerr++;
        if (bus.vram_we !== bus.host_gnt) aerr++;
        if (bus.host_gnt === 1'b1 && bus.vram_addr !== bus.host_addr) aerr++;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    bus.line_done = 1'b0;
    bus.host_req = 1'b0;
    if (rk < 0) check_output("line_ready_timeout", 32'(k), 32'(0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : apply_stimulus
    int rk, gerr, aerr, hold_err, dly, errs;
    for (int i = 0; i < VRAM_DEPTH; i++) begin
      vram_mem[i] = pattern(i);
      ref_mem[i]  = pattern(i);
    end
    rst = 1'b1;
    bus.start = 1'b0;
    bus.host_req = 1'b0;
    bus.host_addr = '0;
    bus.host_din = '0;
    bus.line_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_lb_we", 32'(bus.lb_we), 32'(0));
    check_output("rst_lb_addr", 32'(bus.lb_addr), 32'(0));
    check_output("rst_line_ready", 32'(bus.line_ready), 32'(0));
    check_output("rst_line_num", 32'(bus.line_num), 32'(0));
    check_output("rst_busy", 32'(bus.busy), 32'(0));
    check_output("rst_frame_done", 32'(bus.frame_done), 32'(0));
    check_output("rst_host_gnt", 32'(bus.host_gnt), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Scenarios 1 and 2: full frame with no host traffic, random TX consume delays
    $display("[TB] full frame, no host traffic");
    begin_frame();
    fetch_line(0, 0, 0, 1'b0, rk, gerr, aerr);
    check_output("ready_cycle_l0", 32'(rk), 32'(1442));
    check_output("first_we_cycle", 32'(first_we - base_cyc), 32'(2));
    check_output("last_we_cycle", 32'(last_we - base_cyc), 32'(1441));
    check_output("we_count_l0", 32'(n_we), 32'(LINE_BYTES));
    check_output("lb0_l0", 32'(lb_mem[0]), 32'(1));
    check_output("lb1439_l0", 32'(lb_mem[LINE_BYTES - 1]), 32'(20));
    check_output("busy_wait", 32'(bus.busy), 32'(1));
    hold_err = 0;
    for (int ln = 0; ln < NUM_LINES; ln++) begin
      if (ln > 0) begin
        fetch_line(0, 0, 0, 1'b0, rk, gerr, aerr);
        check_output("ready_cycle", 32'(rk), 32'(1442));
        check_output("we_count", 32'(n_we), 32'(LINE_BYTES));
        if (ln == 1) check_output("lb0_l1", 32'(lb_mem[0]), 32'(31));
      end
      check_output("line_num", 32'(bus.line_num), 32'(ln));
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        if (bus.line_ready !== 1'b1) hold_err++;
      end
      bus.line_done = 1'b1;
      n_we = 0;
      if (ln < NUM_LINES - 1) push_line(ln + 1);
      @(negedge clk);
      bus.line_done = 1'b0;
      if (ln < NUM_LINES - 1) begin
        check_output("ready_drop", 32'(bus.line_ready), 32'(0));
      end
    end
    check_output("line_ready_held", 32'(hold_err), 32'(0));
    check_output("frame_done_pulse", 32'(bus.frame_done), 32'(1));
    check_output("busy_after_frame", 32'(bus.busy), 32'(0));
    check_output("ready_after_frame", 32'(bus.line_ready), 32'(0));
    @(negedge clk);
    check_output("frame_done_single", 32'(bus.frame_done), 32'(0));
    check_output("frame_pulse_count", 32'(frame_pulses), 32'(1));

    // Scenario 3: host_req held high through FETCH, alternating grants
    $display("[TB] host flood during fetch");
    begin_frame();
    fetch_line(0, 0, 0, 1'b1, rk, gerr, aerr);
    check_output("ready_cycle_flood", 32'(rk), 32'(2 * LINE_BYTES + 2));
    check_output("gnt_alternation_errs", 32'(gerr), 32'(0));
    check_output("vram_mux_errs", 32'(aerr), 32'(0));
    check_output("we_count_flood", 32'(n_we), 32'(LINE_BYTES));
    errs = 0;
    for (int j = 0; j < LINE_BYTES; j++) if (lb_mem[j] !== pattern(j)) errs++;
    check_output("lb_contents_flood", 32'(errs), 32'(0));
    apply_reset();

    // Scenario 4: host write in IDLE, stray start/line_done during FETCH
    $display("[TB] host write before start, ignored pulses");
    bus.host_req = 1'b1;
    bus.host_addr = VRAM_AW'(5);
    bus.host_din = 8'hAA;
    #1;
    check_output("idle_host_gnt", 32'(bus.host_gnt), 32'(1));
    check_output("idle_vram_we", 32'(bus.vram_we), 32'(1));
    check_output("idle_vram_addr", 32'(bus.vram_addr), 32'(5));
    ref_mem[5] = 8'hAA;
    @(negedge clk);
    bus.host_req = 1'b0;
    begin_frame();
    fetch_line($urandom_range(20, 700), $urandom_range(800, 1400), 0, 1'b0, rk, gerr, aerr);
    check_output("ready_cycle_ignored", 32'(rk), 32'(1442));
    check_output("we_count_ignored", 32'(n_we), 32'(LINE_BYTES));
    check_output("lb5_host", 32'(lb_mem[5]), 32'(8'hAA));
    check_output("line_num_ignored", 32'(bus.line_num), 32'(0));
    apply_reset();

    // Scenario 5: reset mid-line, then a clean refetch
    $display("[TB] reset mid-line");
    begin_frame();
    fetch_line(0, 0, 701, 1'b0, rk, gerr, aerr);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("midrst_lb_we", 32'(bus.lb_we), 32'(0));
    check_output("midrst_lb_addr", 32'(bus.lb_addr), 32'(0));
    check_output("midrst_busy", 32'(bus.busy), 32'(0));
    check_output("midrst_line_ready", 32'(bus.line_ready), 32'(0));
    check_output("midrst_frame_done", 32'(bus.frame_done), 32'(0));
    check_output("midrst_we_count", 32'(n_we), 32'(700));
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    begin_frame();
    fetch_line(0, 0, 0, 1'b0, rk, gerr, aerr);
    check_output("ready_cycle_refetch", 32'(rk), 32'(1442));
    check_output("first_we_refetch", 32'(first_we - base_cyc), 32'(2));
    check_output("we_count_refetch", 32'(n_we), 32'(LINE_BYTES));
    check_output("lb0_refetch", 32'(lb_mem[0]), 32'(1));

    @(negedge clk);
    @(negedge clk);
    check_output("exp_q_left", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
